num_class_generator: RTL and testbench



---
 rtl/num_class_generator_pkg.sv | 28 ++
 rtl/num_class_match.sv | 59 +++++
 rtl/num_class_generator.sv | 102 ++++++++++
 tb/tb_num_class_generator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/num_class_generator_pkg.sv
// Shared definitions for the number-class generator: class select codes,
// FSM state encoding and count sizing.
// Imported by the generator top and its combinational class matcher.
package num_class_generator_pkg;

  // Class select encodings; 6 and 7 are unused and match nothing
  localparam logic [2:0] SEL_PRIME = 3'd0;
  localparam logic [2:0] SEL_MUL2  = 3'd1;
  localparam logic [2:0] SEL_MUL3  = 3'd2;
  localparam logic [2:0] SEL_MUL5  = 3'd3;
  localparam logic [2:0] SEL_MUL7  = 3'd4;
  localparam logic [2:0] SEL_MUL11 = 3'd5;

  // Largest class (even numbers 2..14) has 7 members
  localparam int unsigned MAX_COUNT = 7;
  localparam int unsigned COUNT_W   = $clog2(MAX_COUNT + 1);

  // Final candidate of every scan; the candidate counter never wraps past it
  localparam logic [3:0] LAST_CAND = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/num_class_match.sv
// Combinational class membership test for a 4-bit candidate.
// Zero latency; no flow control.
// Each class is a sum of products over the candidate bits; 0 never matches.
module num_class_match
  import num_class_generator_pkg::*;
(
  input  logic [3:0] cand,
  input  logic [2:0] sel,
  output logic       match
);

  logic b3, b2, b1, b0;
  logic is_prime, is_mul2, is_mul3, is_mul5, is_mul7, is_mul11;

  assign {b3, b2, b1, b0} = cand;

  // 2,3 | 5,7 | 11 | 13
  assign is_prime = (~b3 & ~b2 &  b1      )
                  | (~b3 &  b2 &        b0)
                  | ( b3 & ~b2 &  b1 &  b0)
                  | ( b3 &  b2 & ~b1 &  b0);

  // any even value with some upper bit set, which excludes 0
  assign is_mul2  = (~b0 & b3) | (~b0 & b2) | (~b0 & b1);

  // 3, 6, 9, 12, 15
  assign is_mul3  = (~b3 & ~b2 &  b1 &  b0)
                  | (~b3 &  b2 &  b1 & ~b0)
                  | ( b3 & ~b2 & ~b1 &  b0)
                  | ( b3 &  b2 & ~b1 & ~b0)
                  | ( b3 &  b2 &  b1 &  b0);

  // 5, 10, 15
  assign is_mul5  = (~b3 &  b2 & ~b1 &  b0)
                  | ( b3 & ~b2 &  b1 & ~b0)
                  | ( b3 &  b2 &  b1 &  b0);

  // 7, 14
  assign is_mul7  = (~b3 &  b2 &  b1 &  b0)
                  | ( b3 &  b2 &  b1 & ~b0);

  // 11
  assign is_mul11 = ( b3 & ~b2 &  b1 &  b0);

  // Pick the selected class; unused select codes match nothing
  always_comb begin
    match = 1'b0;
    case (sel)
      SEL_PRIME: match = is_prime;
      SEL_MUL2:  match = is_mul2;
      SEL_MUL3:  match = is_mul3;
      SEL_MUL5:  match = is_mul5;
      SEL_MUL7:  match = is_mul7;
      SEL_MUL11: match = is_mul11;
      default:   match = 1'b0;
    endcase
  end

endmodule

// File: rtl/num_class_generator.sv
// Scans candidates 0..15 and streams every member of the selected class.
// One candidate per cycle; a match appears on out_valid the cycle after it is checked.
// out_valid/out_num hold until out_ready; the scan pauses while stalled.
module num_class_generator
  import num_class_generator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] sel,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_num,
  output logic       busy,
  output logic       done,
  output logic [2:0] count
);

  state_t               state_q, state_d;
  logic [3:0]           cand_q,  cand_d;
  logic [2:0]           sel_q,   sel_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [3:0]           num_q,   num_d;
  logic                 match;

  // Class test runs against the latched select so mid-scan sel changes are inert
  num_class_match u_match (
    .cand  (cand_q),
    .sel   (sel_q),
    .match (match)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      sel_q   <= 3'd0;
      count_q <= '0;
      num_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      num_q   <= num_d;
    end
  end

  // Next-state and datapath updates for the scan/emit sequence
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    sel_d   = sel_q;
    count_d = count_q;
    num_d   = num_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = sel;
          count_d = '0;
          cand_d  = 4'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          num_d   = cand_q;
          state_d = EMIT;
        end else if (cand_q == LAST_CAND) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + 4'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          count_d = count_q + 1'b1;
          if (cand_q == LAST_CAND) begin
            state_d = DONE;
          end else begin
            cand_d  = cand_q + 4'd1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign out_num   = num_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count     = count_q;

endmodule

// File: tb/tb_num_class_generator.sv
// Self-checking bench for num_class_generator: table of class scans run
// back-to-back, plus hand-written back-pressure, invalid-select timing,
// start-while-busy and reset-mid-emit sequences.
module tb_num_class_generator;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic [2:0] sel       = 3'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_num;
  logic       busy;
  logic       done;
  logic [2:0] count;

  int total     = 0;
  int passed    = 0;
  int done_seen = 0;

  logic [3:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_num   = 4'd0;

  typedef struct {
    logic [2:0] sel;
    int         exp_count;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  num_class_generator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sel       (sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_num   (out_num),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference class membership from arithmetic, independent of any gate form
  function automatic bit model_member(input int n, input logic [2:0] s);
    case (s)
      3'd0: return (n == 2 || n == 3 || n == 5 || n == 7 || n == 11 || n == 13);
      3'd1: return (n != 0 && n % 2 == 0);
      3'd2: return (n != 0 && n % 3 == 0);
      3'd3: return (n != 0 && n % 5 == 0);
      3'd4: return (n != 0 && n % 7 == 0);
      3'd5: return (n != 0 && n % 11 == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard and hold checker, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_num_held", out_num, prev_num);
      end
      if (out_valid && out_ready) begin
        check("output_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) check("out_num", out_num, exp_q.pop_front());
      end
      if (done) done_seen++;
      prev_stall = out_valid && !out_ready;
      prev_num   = out_num;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_num"},   out_num,   0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_count"},     count,     0);
  endtask

  // Drive a one-cycle start and queue the model's expected members
  task automatic start_scan(input logic [2:0] s);
    sel   = s;
    start = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (model_member(n, s)) exp_q.push_back(n[3:0]);
    end
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_count_clear", count, 0);
  endtask

  task automatic wait_done(input string tag, input int exp_count, output int cycles);
    int d0;
    d0     = done_seen;
    cycles = 0;
    while (!done && cycles < 80) begin
      step();
      cycles++;
    end
    check({tag, "_done_reached"}, done, 1);
    if (done) begin
      check({tag, "_count"}, count, exp_count);
      check({tag, "_queue_drained"}, exp_q.size(), 0);
      step();
      check({tag, "_busy_after_done"}, busy, 0);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_done_pulses"}, done_seen - d0, 1);
      check({tag, "_count_held"}, count, exp_count);
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid_seen"}, out_valid, 1);
  endtask

  initial begin
    int cyc;
    int d0;

    vecs[0] = '{3'd0, 6};
    vecs[1] = '{3'd1, 7};
    vecs[2] = '{3'd2, 5};
    vecs[3] = '{3'd3, 3};
    vecs[4] = '{3'd4, 2};
    vecs[5] = '{3'd5, 1};
    vecs[6] = '{3'd6, 0};
    vecs[7] = '{3'd7, 0};

    reset = 1'b1;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("post_reset");

    // Table sweep; each start lands in the IDLE cycle right after the prior done
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_scan(vecs[i].sel);
      wait_done($sformatf("vec%0d_sel%0d", i, vecs[i].sel), vecs[i].exp_count, cyc);
    end

    // Invalid select: 16 scan cycles, then done
    start_scan(3'd6);
    wait_done("invalid", 0, cyc);
    check("invalid_scan_cycles", cyc, 16);

    // Back-pressure on multiples of 5
    out_ready = 1'b0;
    start_scan(3'd3);
    wait_valid("bp", cyc);
    check("bp_first_latency", cyc, 6);
    check("bp_first_num", out_num, 5);
    repeat (5) step();
    check("bp_valid_after_stall", out_valid, 1);
    check("bp_num_after_stall", out_num, 5);
    out_ready = 1'b1;
    wait_done("bp", 3, cyc);

    // Start and sel changes while busy are ignored
    start_scan(3'd4);
    step();
    step();
    sel   = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("busy_start", 2, cyc);
    repeat (3) step();
    check("busy_start_stays_idle", busy, 0);

    // Reset while 4 is being offered on a multiples-of-2 scan
    out_ready = 1'b1;
    start_scan(3'd1);
    wait_valid("rst_first", cyc);
    check("rst_first_num", out_num, 2);
    step();
    out_ready = 1'b0;
    wait_valid("rst_second", cyc);
    check("rst_second_num", out_num, 4);
    d0    = done_seen;
    reset = 1'b1;
    step();
    check_idle("mid_emit_reset");
    reset = 1'b0;
    exp_q.delete();
    step();
    check("mid_emit_no_done", done_seen - d0, 0);
    check("mid_emit_still_idle", busy, 0);

    out_ready = 1'b1;
    start_scan(3'd1);
    wait_done("after_reset", 7, cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
